cr16_controller: RTL and testbench

Multi-cycle fetch/decode/execute control unit for the CR16 core, sitting directly upstream of `datapath`. It fetches 16-bit instructions from a synchronous memory and decodes them. It drives every datapath control input: register write enables, A/B selects, immediate, ALU opcode and regfile-data mux. It also owns the program counter, the instruction register and the latched status flags used by branches.

---
 rtl/cr16_controller.sv | 219 +++++++++++++++++++++
 tb/tb_cr16_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_controller.sv
// cr16_controller: multi-cycle fetch/decode/execute control unit for the CR16 core.
// Owns the PC, instruction register and latched status flags, and drives every
// datapath control input.
//
// Optional feature macro: CR16_CONTROLLER_HALT_ON_ILLEGAL_EN
//   defined   - an illegal instruction enters HALT until reset
//   undefined - an illegal instruction acts as a NOP
//
// Ports:
//   I_CLK, I_RESET (async, active-high), I_ENABLE (freeze when low)
//   I_MEM_DATA        memory read data (one cycle after address)
//   I_A, I_B          datapath register read values
//   I_STATUS_FLAGS    datapath flags {N,Z,F,L,C}
//   O_MEM_ADDR/WE/DATA              memory interface
//   O_REG_WRITE_ENABLE              one-hot register write enable
//   O_REG_A_SELECT/O_REG_B_SELECT   register read selects
//   O_IMMEDIATE/O_IMMEDIATE_SELECT  immediate operand
//   O_OPCODE                        ALU code
//   O_REGFILE_DATA/_SELECT          direct write-data path (MOV/MOVI/LOAD)
//   O_ILLEGAL                       one-cycle pulse on an undecodable instruction
module cr16_controller #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  I_ENABLE,
  input  logic [15:0]           I_MEM_DATA,
  input  logic [15:0]           I_A,
  input  logic [15:0]           I_B,
  input  logic [4:0]            I_STATUS_FLAGS,
  output logic [ADDR_WIDTH-1:0] O_MEM_ADDR,
  output logic                  O_MEM_WE,
  output logic [15:0]           O_MEM_DATA,
  output logic [15:0]           O_REG_WRITE_ENABLE,
  output logic [3:0]            O_REG_A_SELECT,
  output logic [3:0]            O_REG_B_SELECT,
  output logic [15:0]           O_IMMEDIATE,
  output logic                  O_IMMEDIATE_SELECT,
  output logic [3:0]            O_OPCODE,
  output logic [15:0]           O_REGFILE_DATA,
  output logic                  O_REGFILE_DATA_SELECT,
  output logic                  O_ILLEGAL
);

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StWriteback, StHalt} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [4:0]            flags_q, flags_d;

  logic [3:0]  op, rd, ext, rs, code;
  logic [7:0]  imm8;
  logic [15:0] imm_sext, imm_zext, rd_onehot;
  logic [ADDR_WIDTH-1:0] disp_ext;
  logic        is_itype, is_load, is_store, is_branch;
  logic        alu_ok, alu_write, alu_flags, alu_sext, alu_mov;
  logic [3:0]  alu_opc;
  logic        br_ok, br_taken, legal;

  assign op        = ir_q[15:12];
  assign rd        = ir_q[11:8];
  assign ext       = ir_q[7:4];
  assign rs        = ir_q[3:0];
  assign imm8      = ir_q[7:0];
  assign imm_sext  = {{8{imm8[7]}}, imm8};
  assign imm_zext  = {8'h00, imm8};
  assign disp_ext  = {{(ADDR_WIDTH-8){imm8[7]}}, imm8};
  assign rd_onehot = 16'h0001 << rd;
  assign is_itype  = (op != 4'b0000);
  assign is_load   = (op == 4'b0100) && (ext == 4'b0000);
  assign is_store  = (op == 4'b0100) && (ext == 4'b0100);
  assign is_branch = (op == 4'b1100);
  // I-type ALU ops reuse the R-type ext encoding as their op field.
  assign code      = is_itype ? op : ext;

  // Instruction decode
  always_comb begin
    alu_ok    = 1'b0;
    alu_write = 1'b0;
    alu_flags = 1'b0;
    alu_sext  = 1'b0;
    alu_mov   = 1'b0;
    alu_opc   = 4'd0;
    unique case (code)
      4'b0101: begin alu_ok = 1'b1; alu_opc = 4'd0; alu_write = 1'b1; alu_flags = 1'b1; alu_sext = 1'b1; end
      4'b1001: begin alu_ok = 1'b1; alu_opc = 4'd3; alu_write = 1'b1; alu_flags = 1'b1; alu_sext = 1'b1; end
      4'b1011: begin alu_ok = 1'b1; alu_opc = 4'd3; alu_flags = 1'b1; alu_sext = 1'b1; end
      4'b0001: begin alu_ok = 1'b1; alu_opc = 4'd5; alu_write = 1'b1; end
      4'b0010: begin alu_ok = 1'b1; alu_opc = 4'd6; alu_write = 1'b1; end
      4'b0011: begin alu_ok = 1'b1; alu_opc = 4'd7; alu_write = 1'b1; end
      4'b1101: begin alu_ok = 1'b1; alu_mov = 1'b1; end
      default: ;
    endcase

    br_ok    = 1'b1;
    br_taken = 1'b0;
    unique case (rd)
      4'b0000: br_taken = flags_q[3];   // EQ: Z set
      4'b0001: br_taken = !flags_q[3];  // NE
      4'b1101: br_taken = !flags_q[4];  // GE: N clear
      4'b1110: br_taken = 1'b1;         // UC
      default: br_ok = 1'b0;
    endcase

    if (op == 4'b0100)  legal = is_load || is_store;
    else if (is_branch) legal = br_ok;
    else                legal = alu_ok;
  end

  // Next state and control outputs
  always_comb begin
    state_d               = state_q;
    pc_d                  = pc_q;
    ir_d                  = ir_q;
    flags_d               = flags_q;
    O_MEM_ADDR            = pc_q;
    O_MEM_WE              = 1'b0;
    O_MEM_DATA            = '0;
    O_REG_WRITE_ENABLE    = '0;
    O_REG_A_SELECT        = '0;
    O_REG_B_SELECT        = '0;
    O_IMMEDIATE           = '0;
    O_IMMEDIATE_SELECT    = 1'b0;
    O_OPCODE              = '0;
    O_REGFILE_DATA        = '0;
    O_REGFILE_DATA_SELECT = 1'b0;
    O_ILLEGAL             = 1'b0;

    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        ir_d    = I_MEM_DATA;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = StExecute;
      end
      StExecute: begin
        state_d = StFetch;
        if (!legal) begin
          O_ILLEGAL = 1'b1;
`ifdef CR16_CONTROLLER_HALT_ON_ILLEGAL_EN
          state_d = StHalt;
`endif
        end else if (is_load) begin
          O_REG_A_SELECT = rs;
          O_MEM_ADDR     = ADDR_WIDTH'(I_A);
          state_d        = StWriteback;
        end else if (is_store) begin
          O_REG_A_SELECT = rs;
          O_REG_B_SELECT = rd;
          O_MEM_ADDR     = ADDR_WIDTH'(I_A);
          O_MEM_DATA     = I_B;
          O_MEM_WE       = 1'b1;
        end else if (is_branch) begin
          // PC already points past the branch; the target is relative to the branch itself.
          if (br_taken) pc_d = pc_q - ADDR_WIDTH'(1) + disp_ext;
        end else if (alu_mov) begin
          if (is_itype) begin
            O_IMMEDIATE    = imm_zext;
            O_REGFILE_DATA = imm_zext;
          end else begin
            O_REG_B_SELECT = rs;
            O_REGFILE_DATA = I_B;
          end
          O_REGFILE_DATA_SELECT = 1'b1;
          O_REG_WRITE_ENABLE    = rd_onehot;
        end else begin
          O_REG_A_SELECT = rd;
          O_OPCODE       = alu_opc;
          if (is_itype) begin
            O_IMMEDIATE        = alu_sext ? imm_sext : imm_zext;
            O_IMMEDIATE_SELECT = 1'b1;
          end else begin
            O_REG_B_SELECT = rs;
          end
          if (alu_write) O_REG_WRITE_ENABLE = rd_onehot;
          if (alu_flags) flags_d = I_STATUS_FLAGS;
        end
      end
      StWriteback: begin
        O_REG_A_SELECT        = rs;
        O_MEM_ADDR            = ADDR_WIDTH'(I_A);
        O_REGFILE_DATA        = I_MEM_DATA;
        O_REGFILE_DATA_SELECT = 1'b1;
        O_REG_WRITE_ENABLE    = rd_onehot;
        state_d               = StFetch;
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase

    // Freeze: hold all state and suppress every strobe.
    if (!I_ENABLE) begin
      state_d            = state_q;
      pc_d               = pc_q;
      ir_d               = ir_q;
      flags_d            = flags_q;
      O_MEM_WE           = 1'b0;
      O_REG_WRITE_ENABLE = '0;
      O_ILLEGAL          = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_cr16_controller.sv
// Directed bench for cr16_controller. A small register file / ALU / memory environment
// closes the loop around the controller; expected values are hand-computed per cycle.
module tb_cr16_controller;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] mem_rdata;
  logic [15:0] a_val, b_val;
  logic [4:0]  flags;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, we, imm, rf_data;
  logic [3:0]  a_sel, b_sel, opcode;
  logic        imm_sel, rf_sel, illegal;

  always #5 clk = ~clk;

  cr16_controller dut (
    .I_CLK                 (clk),
    .I_RESET               (rst),
    .I_ENABLE              (en),
    .I_MEM_DATA            (mem_rdata),
    .I_A                   (a_val),
    .I_B                   (b_val),
    .I_STATUS_FLAGS        (flags),
    .O_MEM_ADDR            (mem_addr),
    .O_MEM_WE              (mem_we),
    .O_MEM_DATA            (mem_wdata),
    .O_REG_WRITE_ENABLE    (we),
    .O_REG_A_SELECT        (a_sel),
    .O_REG_B_SELECT        (b_sel),
    .O_IMMEDIATE           (imm),
    .O_IMMEDIATE_SELECT    (imm_sel),
    .O_OPCODE              (opcode),
    .O_REGFILE_DATA        (rf_data),
    .O_REGFILE_DATA_SELECT (rf_sel),
    .O_ILLEGAL             (illegal)
  );

  // Environment: program ROM at 0..31, data RAM elsewhere, register file and ALU.
  logic [15:0] rom  [32];
  logic [15:0] dmem [256];
  logic [15:0] regs [16];
  logic        env_clear;
  logic [15:0] alu_b, result, wdata;

  assign a_val = regs[a_sel];
  assign b_val = regs[b_sel];

  always_comb begin
    alu_b = imm_sel ? imm : b_val;
    case (opcode)
      4'd3:    result = a_val - alu_b;
      4'd5:    result = a_val & alu_b;
      4'd6:    result = a_val | alu_b;
      4'd7:    result = a_val ^ alu_b;
      default: result = a_val + alu_b;
    endcase
    wdata = rf_sel ? rf_data : result;
    flags = {result[15], result == 16'h0000, 3'b000};
  end

  always @(posedge clk) begin
    mem_rdata <= (mem_addr < 16'd32) ? rom[mem_addr[4:0]] : dmem[mem_addr[7:0]];
    if (mem_we) dmem[mem_addr[7:0]] <= mem_wdata;
    for (int i = 0; i < 16; i++) begin
      if (env_clear)  regs[i] <= 16'h0000;
      else if (we[i]) regs[i] <= wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
    cyc += n;
  endtask

  task automatic goto(input int c);
    tick(c - cyc);
  endtask

  // Reset with env clear; returns at cycle 0 sample point with reset released.
  task automatic do_reset();
    rst = 1'b1;
    env_clear = 1'b1;
    tick(2);
    rst = 1'b0;
    env_clear = 1'b0;
    #1;
    cyc = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h5105;  // ADDI R1,5
    rom[1]  = 16'h0251;  // ADD  R2,R1
    rom[2]  = 16'hD3FF;  // MOVI R3,0xFF
    rom[3]  = 16'h93FF;  // SUBI R3,-1
    rom[4]  = 16'h5240;  // ADDI R2,0x40 -> 0x45
    rom[5]  = 16'h4142;  // STOR R1,R2
    rom[6]  = 16'h4402;  // LOAD R4,R2
    rom[7]  = 16'hCE02;  // BUC  +2 -> 9
    rom[8]  = 16'hCE04;  // BUC  +4 -> 12
    rom[9]  = 16'h01B1;  // CMP  R1,R1
    rom[10] = 16'hC0FE;  // BEQ  -2 -> 8
    rom[12] = 16'hB100;  // CMPI R1,0
    rom[13] = 16'hC0FE;  // BEQ  -2 (not taken)
    rom[14] = 16'hF000;  // illegal
    rom[15] = 16'h5601;  // ADDI R6,1
    rom[16] = 16'hCE00;  // BUC  0 (self loop)

    en = 1'b1;
    rst = 1'b1;
    env_clear = 1'b1;
    tick(2);
    check_eq("rst_addr", mem_addr, 16'h0000);
    check_eq("rst_we", we, 16'h0000);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_misc", {opcode, imm, imm_sel, rf_data, rf_sel, a_sel, b_sel}, 0);
    rst = 1'b0;
    env_clear = 1'b0;
    #1;
    cyc = 0;

    // Main program
    check_eq("fetch0_addr", mem_addr, 16'h0000);
    goto(2);
    check_eq("addi_we", we, 16'h0002);
    check_eq("addi_imm", {imm_sel, imm}, {1'b1, 16'h0005});
    goto(5);
    check_eq("add_we", we, 16'h0004);
    check_eq("add_sel", {a_sel, b_sel}, {4'd2, 4'd1});
    goto(6);
    check_eq("r2", regs[2], 16'h0005);
    goto(8);
    check_eq("movi_rf", {rf_sel, rf_data}, {1'b1, 16'h00FF});
    check_eq("movi_we", we, 16'h0008);
    goto(11);
    check_eq("subi_op", {opcode, imm}, {4'd3, 16'hFFFF});
    goto(12);
    check_eq("r3", regs[3], 16'h0100);
    goto(17);
    check_eq("stor", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0045, 16'h0005});
    goto(18);
    check_eq("stor_done", mem_we, 0);
    goto(20);
    check_eq("load_exec", {we, mem_addr}, {16'h0000, 16'h0045});
    goto(21);
    check_eq("load_wb_we", we, 16'h0010);
    check_eq("load_wb_rf", {rf_sel, rf_data}, {1'b1, 16'h0005});
    goto(22);
    check_eq("r4", regs[4], 16'h0005);
    check_eq("pc_after_load", mem_addr, 16'h0007);
    goto(25);
    check_eq("buc_target", mem_addr, 16'h0009);
    goto(27);
    check_eq("cmp", {opcode, we}, {4'd3, 16'h0000});
    goto(31);
    check_eq("beq_taken", mem_addr, 16'h0008);
    goto(34);
    check_eq("buc_fwd", mem_addr, 16'h000C);
    goto(40);
    check_eq("beq_not_taken", mem_addr, 16'h000E);
    goto(42);
    check_eq("illegal_pulse", {illegal, we, mem_we}, {1'b1, 16'h0000, 1'b0});
    goto(43);
    check_eq("illegal_end", illegal, 0);
    check_eq("after_illegal_addr", mem_addr, 16'h000F);
`ifdef CR16_CONTROLLER_HALT_ON_ILLEGAL_EN
    goto(45);
    check_eq("halt_no_we", we, 16'h0000);
    goto(49);
    check_eq("halt_pc", mem_addr, 16'h000F);
`else
    goto(45);
    check_eq("next_we", we, 16'h0040);
    goto(46);
    check_eq("self_loop", mem_addr, 16'h0010);
    goto(49);
    check_eq("self_loop2", mem_addr, 16'h0010);
    check_eq("r6", regs[6], 16'h0001);
`endif

    // Freeze during EXECUTE of the first ADDI
    do_reset();
    goto(2);
    check_eq("frz_pre_we", we, 16'h0002);
    en = 1'b0;
    #1;
    check_eq("frz_we0", we, 16'h0000);
    tick(3);
    check_eq("frz_we_mid", we, 16'h0000);
    check_eq("frz_addr", mem_addr, 16'h0001);
    tick(1);
    check_eq("frz_r1", regs[1], 16'h0000);
    en = 1'b1;
    #1;
    check_eq("frz_release_we", we, 16'h0002);
    tick(1);
    check_eq("frz_r1_after", regs[1], 16'h0005);
    check_eq("frz_next_pc", mem_addr, 16'h0001);

    // Reset during LOAD writeback
    do_reset();
    goto(21);
    check_eq("rwb_we", we, 16'h0010);
    rst = 1'b1;
    #1;
    check_eq("rwb_async_we", we, 16'h0000);
    check_eq("rwb_async_addr", mem_addr, 16'h0000);
    tick(2);
    check_eq("rwb_r4", regs[4], 16'h0000);
    rst = 1'b0;
    #1;
    check_eq("rwb_pc", mem_addr, 16'h0000);
    tick(2);
    check_eq("rwb_restart", we, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
